// File: rtl/equalizer_pkg.sv
// rtl/equalizer_pkg.sv - shared widths, band indices and FIR coefficient table for the equalizer
package equalizer_pkg;

  localparam int NUM_BANDS  = 8;
  localparam int NUM_TAPS   = 32;
  localparam int SAMPLE_W   = 16;
  localparam int COEF_W     = 16;
  localparam int COEF_FRAC  = 15;
  localparam int PROD_W     = 32;
  localparam int ACC_W      = 40;
  localparam int OUT_W      = 16;
  localparam int GAIN_W     = 8;
  localparam int GAIN_FRAC  = 2;
  localparam int GAIN_UNITY = 1 << GAIN_FRAC;
  localparam int AMP_W      = 24;
  localparam int SUM_W      = 28;
  localparam int PHASE_W    = 6;
  localparam int TAP_W      = 5;
  localparam int BAND_W     = 3;
  localparam int MAC_LAST   = 32;

  localparam int BAND_LPF_1000HZ         = 0;
  localparam int BAND_BPF_1000HZ2000HZ   = 1;
  localparam int BAND_BPF_2000HZ3000HZ   = 2;
  localparam int BAND_BPF_3000HZ4000HZ   = 3;
  localparam int BAND_BPF_4000HZ5000HZ   = 4;
  localparam int BAND_BPF_5000HZ6000HZ   = 5;
  localparam int BAND_BPF_6000HZ7000HZ   = 6;
  localparam int BAND_HPF_7000HZ         = 7;

  // Quarter-wave cosine, cos(2*pi*i/32) in Q1.15
  function automatic int quarter_cos(input int i);
    case (i)
      0: return 32767;
      1: return 32137;
      2: return 30274;
      3: return 27246;
      4: return 23170;
      5: return 18205;
      6: return 12540;
      7: return 6393;
      default: return 0;
    endcase
  endfunction

  function automatic int cos32(input int j);
    int m;
    m = j & 31;
    if (m <= 8)  return quarter_cos(m);
    if (m <= 16) return -quarter_cos(16 - m);
    if (m <= 24) return -quarter_cos(m - 16);
    return quarter_cos(32 - m);
  endfunction

  // Hann-windowed cosine centred on (band+0.5) kHz; the eight bands sum to a delayed unit impulse
  function automatic logic signed [COEF_W-1:0] coef_value(input int band, input int tap);
    int v;
    v = ((32767 - cos32(tap)) * cos32((2 * band + 1) * (tap - 16))) >>> 19;
    return v[COEF_W-1:0];
  endfunction

  typedef logic [NUM_BANDS*NUM_TAPS*COEF_W-1:0] coef_table_t;

  function automatic coef_table_t build_coef_table();
    coef_table_t t;
    t = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      for (int n = 0; n < NUM_TAPS; n++) begin
        t[(b*NUM_TAPS+n)*COEF_W +: COEF_W] = coef_value(b, n);
      end
    end
    return t;
  endfunction

  localparam coef_table_t COEF_TABLE = build_coef_table();

endpackage

// File: rtl/eq_band_fir.sv
// rtl/eq_band_fir.sv - one 32-tap serial-MAC FIR band with round-half-up and 16-bit saturation
module eq_band_fir
  import equalizer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_clear,
  input  logic                       i_mac,
  input  logic [BAND_W-1:0]          i_band_sel,
  input  logic [TAP_W-1:0]           i_tap,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [OUT_W-1:0]    o_result
);

  localparam logic signed [ACC_W-1:0] ROUND_HALF  = ACC_W'(1 << (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] ACC_OUT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] ACC_OUT_MIN = ACC_W'(-32768);

  logic signed [COEF_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_rounded;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_coef = COEF_TABLE[{i_band_sel, i_tap}*COEF_W +: COEF_W];
  assign w_prod = i_sample * w_coef;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_mac) begin
        r_acc <= r_acc + ACC_W'(w_prod);
      end
    end
  end

  // Held accumulator is valid from the last tap until the next frame clears it
  always_comb begin
    w_rounded = (r_acc + ROUND_HALF) >>> COEF_FRAC;
    o_result  = w_rounded[OUT_W-1:0];
    if (w_rounded > ACC_OUT_MAX) begin
      o_result = OUT_W'(32767);
    end else if (w_rounded < ACC_OUT_MIN) begin
      o_result = OUT_W'(-32768);
    end
  end

endmodule

// File: rtl/equalizer.sv
// rtl/equalizer.sv - 8-band FIR graphic equalizer: delay line, phase counter, gains and summer
module equalizer
  import equalizer_pkg::*;
#(
  parameter int FILTER_IN_BITS    = 16,
  parameter int FILTER_OUT_BITS   = 16,
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int GAIN_BITS         = 8,
  parameter int GAIN_FRAC_BITS    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_enable,
  input  logic                                   amplifier_enable,
  input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
  input  logic signed [FILTER_IN_BITS-1:0]       filter_in,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_out,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_lpf_1000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_1000hz2000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_2000hz3000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_3000hz4000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_4000hz5000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_5000hz6000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_6000hz7000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_hpf_7000hz
);

  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(-32768);

  logic [PHASE_W-1:0]         r_phase;
  logic signed [SAMPLE_W-1:0] r_dline [NUM_TAPS];
  logic signed [OUT_W-1:0]    r_band  [NUM_BANDS];
  logic signed [OUT_W-1:0]    r_out;

  logic                       w_capture;
  logic                       w_mac;
  logic [TAP_W-1:0]           w_tap;
  logic signed [SAMPLE_W-1:0] w_sample;
  logic signed [OUT_W-1:0]    w_band [NUM_BANDS];
  logic signed [GAIN_W-1:0]   w_gain [NUM_BANDS];
  logic signed [AMP_W-1:0]    w_amp  [NUM_BANDS];
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [OUT_W-1:0]    w_out;

  // Phase 0 captures and publishes; phases 1..32 walk taps 0..31
  assign w_capture = (r_phase == '0);
  assign w_mac     = !w_capture && (r_phase <= PHASE_W'(MAC_LAST));
  assign w_tap     = TAP_W'(r_phase - PHASE_W'(1));
  assign w_sample  = r_dline[w_tap];

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    eq_band_fir u_fir (
      .clk       (clk),
      .rst       (rst),
      .i_en      (clk_enable),
      .i_clear   (w_capture),
      .i_mac     (w_mac),
      .i_band_sel(BAND_W'(g)),
      .i_tap     (w_tap),
      .i_sample  (w_sample),
      .o_result  (w_band[g])
    );

    assign w_gain[g] = amplifier_enable ? $signed(amplifier_gains[g*GAIN_BITS +: GAIN_BITS])
                                        : GAIN_W'(GAIN_UNITY);
    assign w_amp[g]  = (AMP_W'(w_band[g]) * AMP_W'(w_gain[g])) >>> GAIN_FRAC_BITS;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      w_sum = w_sum + SUM_W'(w_amp[i]);
    end
  end

  always_comb begin
    w_out = w_sum[OUT_W-1:0];
    if (w_sum > SUM_MAX) begin
      w_out = OUT_W'(32767);
    end else if (w_sum < SUM_MIN) begin
      w_out = OUT_W'(-32768);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_out   <= '0;
      for (int i = 0; i < NUM_TAPS; i++) r_dline[i] <= '0;
      for (int i = 0; i < NUM_BANDS; i++) r_band[i] <= '0;
    end else if (clk_enable) begin
      r_phase <= r_phase + PHASE_W'(1);
      if (w_capture) begin
        r_dline[0] <= filter_in;
        for (int i = 1; i < NUM_TAPS; i++) r_dline[i] <= r_dline[i-1];
        for (int i = 0; i < NUM_BANDS; i++) r_band[i] <= w_band[i];
        r_out <= w_out;
      end
    end
  end

  assign filter_out              = r_out;
  assign filter_lpf_1000hz       = r_band[BAND_LPF_1000HZ];
  assign filter_bpf_1000hz2000hz = r_band[BAND_BPF_1000HZ2000HZ];
  assign filter_bpf_2000hz3000hz = r_band[BAND_BPF_2000HZ3000HZ];
  assign filter_bpf_3000hz4000hz = r_band[BAND_BPF_3000HZ4000HZ];
  assign filter_bpf_4000hz5000hz = r_band[BAND_BPF_4000HZ5000HZ];
  assign filter_bpf_5000hz6000hz = r_band[BAND_BPF_5000HZ6000HZ];
  assign filter_bpf_6000hz7000hz = r_band[BAND_BPF_6000HZ7000HZ];
  assign filter_hpf_7000hz       = r_band[BAND_HPF_7000HZ];

endmodule

// File: tb/tb_equalizer.sv
// tb/tb_equalizer.sv - scoreboard bench for equalizer against a frame-level arithmetic model
module tb_equalizer;
  import equalizer_pkg::*;

  typedef struct packed {
    logic [7:0][15:0] band;
    logic [15:0]      out;
  } exp_t;

  localparam logic [63:0] G_UNITY = {8{8'd4}};
  localparam logic [63:0] G_SWEEP = 64'h0807060504030201;
  localparam logic [63:0] G_P124  = {8{8'd124}};
  localparam logic [63:0] G_N128  = {8{8'h80}};

  logic               clk = 0;
  logic               rst = 1;
  logic               clk_enable = 0;
  logic               amplifier_enable = 1;
  logic [63:0]        amplifier_gains = G_UNITY;
  logic signed [15:0] filter_in = 0;
  logic signed [15:0] filter_out;
  logic signed [15:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic [7:0][15:0]   act_band;

  exp_t               exp_q [$];
  logic signed [15:0] hist [$];
  exp_t               last_act;
  int                 m_phase = 0;
  int                 n_checks = 0;
  int                 n_fail = 0;

  equalizer dut (
    .clk                    (clk),
    .rst                    (rst),
    .clk_enable             (clk_enable),
    .amplifier_enable       (amplifier_enable),
    .amplifier_gains        (amplifier_gains),
    .filter_in              (filter_in),
    .filter_out             (filter_out),
    .filter_lpf_1000hz      (b0),
    .filter_bpf_1000hz2000hz(b1),
    .filter_bpf_2000hz3000hz(b2),
    .filter_bpf_3000hz4000hz(b3),
    .filter_bpf_4000hz5000hz(b4),
    .filter_bpf_5000hz6000hz(b5),
    .filter_bpf_6000hz7000hz(b6),
    .filter_hpf_7000hz      (b7)
  );

  assign act_band = {b7, b6, b5, b4, b3, b2, b1, b0};

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: convolve the sample history with each band, then gain and sum
  function automatic exp_t model(input logic [63:0] g, input bit amp);
    exp_t e;
    longint acc, r, sum, gv;
    logic signed [7:0] gb;
    sum = 0;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int t = 0; t < hist.size(); t++) acc += longint'(hist[t]) * longint'(coef_value(k, t));
      r = (acc + 16384) >>> 15;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      e.band[k] = r[15:0];
      gb = g[8*k +: 8];
      gv = amp ? longint'(gb) : 4;
      sum += (r * gv) >>> 2;
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    e.out = sum[15:0];
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check("reset_filter_out", longint'(filter_out), 0);
    for (int k = 0; k < 8; k++) check($sformatf("reset_band%0d", k), longint'($signed(act_band[k])), 0);
    exp_q.delete();
    hist.delete();
    last_act = '0;
    m_phase = 0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1;
    exp_q.push_back('0);
  endtask

  task automatic run_frame(input logic signed [15:0] smp, input logic [63:0] g, input bit amp,
                           input int stall_at, input int reset_at);
    filter_in = smp;
    hist.push_front(smp);
    if (hist.size() > 32) void'(hist.pop_back());
    for (int p = 0; p < 64; p++) begin
      if (p == reset_at) begin
        do_reset();
        return;
      end
      if (p == stall_at) begin
        clk_enable = 0;
        repeat (10) cycle();
        clk_enable = 1;
      end
      cycle();
      if (p == 0) filter_in = 16'($urandom);
      if (p == 1) amplifier_gains = rnd64();
      if (p == 10) begin
        amplifier_gains = g;
        amplifier_enable = amp;
        exp_q.push_back(model(g, amp));
      end
    end
  endtask

  // Monitor: tracks enabled edges itself; publishes happen where phase was 0
  initial begin
    bit act, upd;
    exp_t e;
    forever begin
      @(posedge clk);
      act = rst && clk_enable;
      upd = act && (m_phase == 0);
      if (act) m_phase = (m_phase + 1) % 64;
      @(negedge clk);
      if (!rst) continue;
      if (upd) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 8; k++)
            check($sformatf("band%0d", k), longint'($signed(act_band[k])), longint'($signed(e.band[k])));
          check("filter_out", longint'(filter_out), longint'($signed(e.out)));
        end
        last_act.band = act_band;
        last_act.out  = filter_out;
      end else begin
        n_checks++;
        if ({act_band, filter_out} !== {last_act.band, last_act.out}) begin
          n_fail++;
          $display("FAIL hold at t=%0t: got %h, expected %h", $time,
                   {act_band, filter_out}, {last_act.band, last_act.out});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset();
    clk_enable = 1;

    repeat (3) run_frame(16'sd0, rnd64(), 1'b1, -1, -1);

    run_frame(16'sd32767, G_UNITY, 1'b1, -1, -1);
    repeat (32) run_frame(16'sd0, G_UNITY, 1'b1, -1, -1);

    repeat (4) run_frame(16'($urandom), G_SWEEP, 1'b1, -1, -1);
    repeat (2) run_frame(16'($urandom), G_SWEEP, 1'b0, -1, -1);

    for (int i = 0; i < 6; i++)
      run_frame(16'($urandom), rnd64(), 1'($urandom_range(0, 1)), (i == 2) ? 25 : -1, -1);

    repeat (33) run_frame(16'sd32767, G_P124, 1'b1, -1, -1);
    repeat (3) run_frame(16'sd32767, G_N128, 1'b1, -1, -1);

    run_frame(16'($urandom), rnd64(), 1'b1, -1, 20);
    run_frame(16'sd12345, G_UNITY, 1'b1, -1, -1);
    repeat (3) run_frame(16'($urandom), rnd64(), 1'b1, -1, -1);

    cycle();
    cycle();
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
